// File: rtl/maple_pkg.sv
// Shared types and constants for the Maple bus receiver.
package maple_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      END   = 2'd3
   } rx_state_e;

   localparam logic [2:0] START_FALLS = 3'd4;
   localparam logic [2:0] END_FALLS   = 3'd2;

   // Saturating increment for the small pattern-edge counter.
   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/maple_rx_if.sv
// Byte stream from the Maple receiver to the FX2 slave-FIFO writer.
interface maple_rx_if;
   logic       menable;
   logic       mready;
   logic [7:0] mdata;

   modport master (output menable, output mready, output mdata);
   modport slave  (input  menable, input  mready, input  mdata);
endinterface

// File: rtl/maple_sync.sv
// Two-flop synchroniser plus previous-value stage for one Maple line.
module maple_sync (
   input  logic clk,
   input  logic reset,
   input  logic line,
   output logic level,
   output logic fall,
   output logic rise
);
   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Lines idle high, so reset to 1 to avoid a spurious fall on release.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
         prev_r <= 1'b1;
      end else begin
         meta_r <= line;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign level = sync_r;
   assign fall  = prev_r & ~sync_r;
   assign rise  = ~prev_r & sync_r;
endmodule

// File: rtl/maple_rx.sv
// Maple bus receiver: start/end pattern detection and byte deserialisation.
// Define MAPLE_RX_CRC_EN to build the running-XOR frame check driving crc_err.
module maple_rx
   import maple_pkg::*;
#(
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sdcka,
   input  logic       sdckb,
   maple_rx_if.master mbus,
   output logic       frame_err,
   output logic       crc_err
);
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(IDLE_TIMEOUT);
   localparam logic [TW-1:0] TMO_ONE = TW'(1);

   logic a_lvl_s, a_fall_s, a_rise_s;
   logic b_lvl_s, b_fall_s, b_rise_s;

   maple_sync u_sync_a (.clk(clk), .reset(reset), .line(sdcka),
                        .level(a_lvl_s), .fall(a_fall_s), .rise(a_rise_s));
   maple_sync u_sync_b (.clk(clk), .reset(reset), .line(sdckb),
                        .level(b_lvl_s), .fall(b_fall_s), .rise(b_rise_s));

   rx_state_e     state_r, state_n;
   logic [2:0]    pat_cnt_r, pat_cnt_n;
   logic [2:0]    bit_cnt_r, bit_cnt_n;
   logic          phase_b_r, phase_b_n;
   logic [6:0]    shift_r, shift_n;
   logic [7:0]    mdata_r, mdata_n;
   logic          mready_r, mready_n;
   logic          menable_r, menable_n;
   logic          frame_err_r, frame_err_n;
   logic [1:0]    hold_r, hold_n;
   logic [TW-1:0] tmo_r, tmo_n;
   logic          a_edge_s, b_edge_s, clash_s, timeout_s;
   logic          abort_s, bit_s, bit_val_s;
   logic          enter_data_s, byte_done_s, frame_ok_s;

   // Next-state, deserialiser and output pulse decode.
   always_comb begin
      state_n      = state_r;
      pat_cnt_n    = pat_cnt_r;
      bit_cnt_n    = bit_cnt_r;
      phase_b_n    = phase_b_r;
      shift_n      = shift_r;
      mdata_n      = mdata_r;
      mready_n     = 1'b0;
      menable_n    = menable_r;
      frame_err_n  = 1'b0;
      hold_n       = (hold_r != 2'd0) ? hold_r - 2'd1 : 2'd0;
      abort_s      = 1'b0;
      bit_s        = 1'b0;
      bit_val_s    = 1'b0;
      enter_data_s = 1'b0;
      byte_done_s  = 1'b0;
      frame_ok_s   = 1'b0;
      a_edge_s     = a_fall_s | a_rise_s;
      b_edge_s     = b_fall_s | b_rise_s;
      clash_s      = a_edge_s & b_edge_s;
      timeout_s    = (tmo_r == TMO_MAX);

      if ((state_r == IDLE) || a_edge_s || b_edge_s) begin
         tmo_n = '0;
      end else if (timeout_s) begin
         tmo_n = tmo_r;
      end else begin
         tmo_n = tmo_r + TMO_ONE;
      end

      case (state_r)
         IDLE: begin
            if ((hold_r == 2'd0) && a_fall_s && b_lvl_s && !b_edge_s) begin
               state_n   = START;
               pat_cnt_n = 3'd0;
            end else begin
               state_n   = IDLE;
            end
         end
         START: begin
            if (timeout_s || clash_s) begin
               abort_s = 1'b1;
            end else if (a_rise_s) begin
               if (pat_cnt_r == START_FALLS) begin
                  state_n      = DATA;
                  menable_n    = 1'b1;
                  bit_cnt_n    = 3'd0;
                  phase_b_n    = 1'b0;
                  enter_data_s = 1'b1;
               end else begin
                  abort_s = 1'b1;
               end
            end else if (b_fall_s && !a_lvl_s) begin
               pat_cnt_n = sat_inc3(pat_cnt_r);
            end else begin
               pat_cnt_n = pat_cnt_r;
            end
         end
         DATA: begin
            if (timeout_s || clash_s) begin
               abort_s = 1'b1;
            end else if (!phase_b_r && a_fall_s) begin
               bit_s     = 1'b1;
               bit_val_s = b_lvl_s;
               phase_b_n = 1'b1;
            end else if (phase_b_r && b_fall_s) begin
               bit_s     = 1'b1;
               bit_val_s = a_lvl_s;
               phase_b_n = 1'b0;
            end else if (!phase_b_r && b_fall_s && a_lvl_s && (bit_cnt_r == 3'd0)) begin
               state_n   = END;
               pat_cnt_n = 3'd0;
            end else if (a_fall_s || b_fall_s) begin
               abort_s = 1'b1;
            end else begin
               state_n = DATA;
            end
         end
         END: begin
            if (timeout_s || clash_s) begin
               abort_s = 1'b1;
            end else if (a_fall_s) begin
               pat_cnt_n = sat_inc3(pat_cnt_r);
            end else if (b_rise_s) begin
               if (pat_cnt_r == END_FALLS) begin
                  state_n    = IDLE;
                  menable_n  = 1'b0;
                  hold_n     = 2'd2;
                  frame_ok_s = 1'b1;
               end else begin
                  abort_s = 1'b1;
               end
            end else begin
               pat_cnt_n = pat_cnt_r;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Bits arrive MSB first; the eighth completes the byte.
      if (bit_s) begin
         if (bit_cnt_r == 3'd7) begin
            mdata_n     = {shift_r, bit_val_s};
            mready_n    = 1'b1;
            byte_done_s = 1'b1;
            bit_cnt_n   = 3'd0;
         end else begin
            shift_n     = {shift_r[5:0], bit_val_s};
            bit_cnt_n   = bit_cnt_r + 3'd1;
         end
      end else begin
         shift_n = shift_r;
      end

      if (abort_s) begin
         state_n     = IDLE;
         menable_n   = 1'b0;
         frame_err_n = 1'b1;
         hold_n      = 2'd2;
      end else begin
         frame_err_n = 1'b0;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         pat_cnt_r   <= 3'd0;
         bit_cnt_r   <= 3'd0;
         phase_b_r   <= 1'b0;
         shift_r     <= 7'd0;
         mdata_r     <= 8'h00;
         mready_r    <= 1'b0;
         menable_r   <= 1'b0;
         frame_err_r <= 1'b0;
         hold_r      <= 2'd0;
         tmo_r       <= '0;
      end else begin
         state_r     <= state_n;
         pat_cnt_r   <= pat_cnt_n;
         bit_cnt_r   <= bit_cnt_n;
         phase_b_r   <= phase_b_n;
         shift_r     <= shift_n;
         mdata_r     <= mdata_n;
         mready_r    <= mready_n;
         menable_r   <= menable_n;
         frame_err_r <= frame_err_n;
         hold_r      <= hold_n;
         tmo_r       <= tmo_n;
      end
   end

   assign mbus.menable = menable_r;
   assign mbus.mready  = mready_r;
   assign mbus.mdata   = mdata_r;
   assign frame_err    = frame_err_r;

`ifdef MAPLE_RX_CRC_EN
   logic [7:0] xor_r;
   logic       crc_err_r;

   // Running XOR over every byte of the frame, checksum byte included.
   always_ff @(posedge clk) begin
      if (reset) begin
         xor_r     <= 8'h00;
         crc_err_r <= 1'b0;
      end else begin
         if (enter_data_s) begin
            xor_r <= 8'h00;
         end else if (byte_done_s) begin
            xor_r <= xor_r ^ mdata_n;
         end else begin
            xor_r <= xor_r;
         end
         crc_err_r <= frame_ok_s && (xor_r != 8'h00);
      end
   end

   assign crc_err = crc_err_r;
`else
   logic unused_crc_s;
   assign unused_crc_s = enter_data_s ^ byte_done_s ^ frame_ok_s;
   assign crc_err      = 1'b0;
`endif
endmodule

// File: doc/maple_rx.md
# maple_rx

Maple bus receiver. Oversamples the two-wire Maple bus (SDCKA/SDCKB), detects the start and end patterns, and deserialises the bit stream into bytes. It presents the bytes to the FX2 slave-FIFO writer on the menable/mready/mdata master interface. It sits directly upstream of that writer: one frame maps to one menable window, which maps to one USB packet.

## Interface
- IDLE_TIMEOUT, default 1024: clk cycles without a line edge, in any non-IDLE state, before the frame is aborted.
- clk  in  1  system clock (48 MHz FX2 IFCLK domain).
- reset  in  1  synchronous, active-high.
- sdcka  in  1  Maple SDCKA, asynchronous, idle high.
- sdckb  in  1  Maple SDCKB, asynchronous, idle high.
- menable  out  1  high for the duration of a received frame.
- mready  out  1  one-cycle pulse per completed byte.
- mdata  out  8  byte valid while mready is high; held until the next byte.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- crc_err  out  1  one-cycle pulse on checksum mismatch (see Configuration).

## Operation
- Both lines pass through a 2-FF synchroniser, then a registered previous-value stage. Each line gives fall and rise strobes.
- States:
  - IDLE
  - START: A has fallen while B is high. Count B falls while A is low.
  - DATA
  - END
- IDLE→START: fall of A while B is high.
- START→DATA: A rises after exactly 4 B falls. Any other count is a frame error.
- On entering DATA, menable=1, bit_cnt=0, phase=A.
- DATA, phase A: a fall of A samples B as the data bit, then phase becomes B.
- DATA, phase B: a fall of B samples A as the data bit, then phase becomes A.
- Bits arrive MSB first. On the 8th bit, mdata takes the byte, mready pulses, and bit_cnt resets to 0.
- DATA→END: B falls while A is high, in phase A, with bit_cnt==0.
- END→IDLE: 2 A falls, then B rises. menable drops at that point.
- Frame error: any of the following pulses frame_err, clears menable and goes to IDLE.
  - END pattern seen with bit_cnt≠0.
  - Wrong-line fall for the current phase, other than the END pattern.
  - Simultaneous A and B edges in one cycle.
  - IDLE_TIMEOUT expiry.
- After any exit to IDLE, menable stays low for at least 2 cycles. A new start is ignored until then.
- Reset mid-frame: everything returns to reset values on the next clk. No mready and no error pulse are produced.
- Reset values: menable=0, mready=0, mdata=8'h00, frame_err=0, crc_err=0, state=IDLE, counters=0.

## Timing
- Latency: mready rises 3 clk after the raw line edge that samples the last bit (2 synchroniser cycles + 1 edge-detect cycle).
- Minimum spacing between mready pulses is 4 clk, because the downstream writer spends 3 cycles per byte. The Maple bit period (≥ 8 clk at 48 MHz) guarantees this.
- menable rises ≥ 3 clk before the first mready, which is covered by the start-pattern duration.
- Timeout counter: width is clog2(IDLE_TIMEOUT+1). It clears on every edge and saturates. It is not active in IDLE.

## Configuration
- MAPLE_RX_CRC_EN defined:
  - A running XOR is kept over all bytes of the frame, including the trailing checksum byte.
  - On a valid END→IDLE, crc_err pulses in the same cycle menable falls, if the XOR≠0.
  - The XOR register clears on entering DATA.
- MAPLE_RX_CRC_EN undefined: no XOR logic is built, and crc_err is tied to 0. The port remains so the top level is unchanged.

## Structure
- Package maple_pkg holds:
  - the rx state enum (IDLE, START, DATA, END);
  - START_FALLS=4;
  - END_FALLS=2.
- Sub-module maple_sync: 2-FF synchroniser plus edge detect for one line, outputs level/fall/rise. It is instantiated twice.

## Test plan
- Reset held, lines toggled → all outputs 0, no mready.
- Start(4 B falls) + bytes 8'hA5, 8'h3C + end → menable high over the frame; 2 mready pulses with mdata A5 then 3C; menable falls after the END rise of B.
- With CRC_EN: bytes 8'h12, 8'h34, 8'h26 (XOR=0) → crc_err=0. Same frame with last byte 8'h27 → crc_err pulses once.
- Start with 3 B falls → frame_err pulse, menable stays 0.
- END pattern after 5 bits of a byte → frame_err, menable drops, no mready for the partial byte.
- Lines frozen low for IDLE_TIMEOUT+1 cycles mid-frame → frame_err, IDLE. A following valid frame is received correctly.
